// File: rtl/uart_fifo_if.sv
// Byte-stream handshake between the register front-end (master) and the UART core (slave).
interface uart_fifo_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic                    rx_valid;
  logic                    rx_ready;

  modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/uart_fifo_core.sv
// UART transceiver with first-word fall-through TX/RX FIFOs, configurable framing
// (5..9 data bits, none/odd/even parity, 1 or 2 stop bits) and sticky line errors.
module uart_fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = LW - 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [LW-1:0] wr_q, rd_q;
  logic          wr_en, rd_en;

  assign level_o = wr_q - rd_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == LW'(DEPTH));
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  assign rd_en   = pop_i && !empty_o;
  // A full FIFO still takes a write when its head leaves on the same edge.
  assign wr_en   = push_i && (!full_o || rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + LW'(1);
      if (rd_en) rd_q <= rd_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module uart_fifo_core #(
  parameter int CLK_HZ       = 10000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_fifo_if.slave    bus,
  input  logic          rx_en,
  input  logic          err_clr,
  input  logic          uart_rxd,
  output logic          uart_txd,
  output logic          tx_busy,
  output logic          rx_frame_err,
  output logic          rx_parity_err,
  output logic          rx_overrun,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level
);
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;
  localparam int STOP_CYC = CPB * STOP_BITS;
  localparam int CW       = $clog2(STOP_CYC + 1);
  localparam int BW       = $clog2(PAYLOAD_BITS + 1);
  localparam int PB       = PAYLOAD_BITS;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  logic [PB-1:0] tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;

  uart_fifo_sync #(.W(PB), .DEPTH(FIFO_DEPTH), .LW(LW)) u_txf (
    .clk, .rst, .push_i(bus.tx_valid && !tx_full), .pop_i(tx_pop), .wdata_i(bus.tx_data),
    .head_o(tx_head), .level_o(tx_level), .full_o(tx_full), .empty_o(tx_empty));

  assign bus.tx_ready = !tx_full;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_head;

  // ---------------- transmitter ----------------
  state_e        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [PB-1:0] tx_sh_q, tx_sh_d;
  logic          tx_par_q, tx_par_d, txd_q, txd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0;
      tx_sh_q <= '0; tx_par_q <= 1'b0; txd_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; txd_q <= txd_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_pop   = !tx_empty;
      end
      S_START: if (tx_cnt_q == CW'(CPB-1)) begin
        tx_st_d = S_DATA; tx_cnt_d = '0; tx_bit_d = '0;
        txd_d = tx_sh_q[0]; tx_sh_d = tx_sh_q >> 1;
      end
      S_DATA: if (tx_cnt_q == CW'(CPB-1)) begin
        tx_cnt_d = '0;
        if (tx_bit_q == BW'(PB-1)) begin
          tx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
          txd_d   = (PARITY != 0) ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
          txd_d = tx_sh_q[0]; tx_sh_d = tx_sh_q >> 1;
        end
      end
      S_PAR: if (tx_cnt_q == CW'(CPB-1)) begin
        tx_st_d = S_STOP; tx_cnt_d = '0; txd_d = 1'b1;
      end
      S_STOP: if (tx_cnt_q == CW'(STOP_CYC-1)) begin
        tx_st_d = S_IDLE; tx_cnt_d = '0; txd_d = 1'b1;
        tx_pop  = !tx_empty;
      end
      default: tx_st_d = S_IDLE;
    endcase
    // Loading from IDLE or straight out of STOP gives gapless back-to-back frames.
    if (tx_pop) begin
      tx_st_d = S_START; tx_cnt_d = '0; txd_d = 1'b0;
      tx_sh_d = tx_head; tx_par_d = (^tx_head) ^ (PARITY == 1);
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (tx_st_q != S_IDLE) || (tx_level != '0);

  // ---------------- receiver ----------------
  state_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [PB-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]    sync_q;
  logic          rxs, rx_prev_q, rx_par_q, rx_par_d;
  logic          fin_q, fin_d, fin_stop_q, fin_stop_d, par_ok;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11; rx_prev_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      rx_par_q <= 1'b0; fin_q <= 1'b0; fin_stop_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rxd}; rx_prev_q <= rxs;
      rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d; fin_q <= fin_d; fin_stop_q <= fin_stop_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    fin_d      = 1'b0;
    fin_stop_d = fin_stop_q;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_en && rx_prev_q && !rxs) rx_st_d = S_START;
      end
      // Mid-start re-check rejects glitches shorter than half a bit.
      S_START: if (rx_cnt_q == CW'(HALF-1)) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_st_d  = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == CW'(CPB-1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxs, rx_sh_q[PB-1:1]};
        if (rx_bit_q == BW'(PB-1)) rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        else                       rx_bit_d = rx_bit_q + BW'(1);
      end
      S_PAR: if (rx_cnt_q == CW'(CPB-1)) begin
        rx_cnt_d = '0; rx_par_d = rxs; rx_st_d = S_STOP;
      end
      S_STOP: if (rx_cnt_q == CW'(CPB-1)) begin
        rx_cnt_d = '0; rx_st_d = S_IDLE;
        fin_d = 1'b1; fin_stop_d = rxs;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  assign par_ok  = (PARITY == 0) || (rx_par_q == ((^rx_sh_q) ^ (PARITY == 1)));
  assign rx_push = fin_q && fin_stop_q && par_ok && !rx_full;

  uart_fifo_sync #(.W(PB), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rxf (
    .clk, .rst, .push_i(rx_push), .pop_i(bus.rx_ready), .wdata_i(rx_sh_q),
    .head_o(rx_head), .level_o(rx_level), .full_o(rx_full), .empty_o(rx_empty));

  // Errors are prioritised frame > parity > overrun; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_frame_err <= 1'b0; rx_parity_err <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      rx_frame_err  <= (fin_q && !fin_stop_q) || (rx_frame_err && !err_clr);
      rx_parity_err <= (fin_q && fin_stop_q && !par_ok) || (rx_parity_err && !err_clr);
      rx_overrun    <= (fin_q && fin_stop_q && par_ok && rx_full) || (rx_overrun && !err_clr);
    end
  end
endmodule
